// File: rtl/fm_pkg.sv
// Shared constants for the FM transmitter: opcodes, controller state encoding
// and the reset increment words derived from the 50 MHz sample clock.
package fm_pkg;

  localparam longint unsigned F_S = 64'd50_000_000;  // modulator clock, Hz
  localparam longint unsigned F_C = 64'd10_000_000;  // default carrier, Hz
  localparam longint unsigned DF  = 64'd75_000;      // default peak deviation, Hz

  localparam int unsigned N_DEF = 18;

  // Rounded phase increment for a frequency on a 2^bits accumulator clocked at F_S.
  function automatic longint unsigned freq_to_inc(input longint unsigned freq,
                                                  input int unsigned bits);
    return ((freq << bits) + F_S / 2) / F_S;
  endfunction

  localparam longint unsigned ACC_INC_DEF = freq_to_inc(F_C, N_DEF);  // 52429
  localparam longint unsigned DF_INC_DEF  = freq_to_inc(DF, N_DEF);   // 393

  localparam logic [7:0] OP_SET_CARRIER = 8'h01;
  localparam logic [7:0] OP_SET_DEV     = 8'h02;
  localparam logic [7:0] OP_ENABLE      = 8'h03;
  localparam logic [7:0] OP_DISABLE     = 8'h04;

  localparam int unsigned CNT_CARRIER = 3;
  localparam int unsigned CNT_DEV     = 2;

  typedef enum logic [1:0] {
    ST_CMD     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/fm_audio_pacer.sv
// Paces audio samples into the modulator: a free-running divider strobes
// audio_req once per AUD_DIV clocks and latches audio_in, or silence when muted.
module fm_audio_pacer #(
  parameter int A       = 8,
  parameter int AUD_DIV = 1134
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tx_en,
  input  logic [A-1:0]        audio_in,
  output logic                audio_req,
  output logic signed [A-1:0] audio
);

  localparam int DIV_W = (AUD_DIV > 2) ? $clog2(AUD_DIV) : 1;

  logic [DIV_W-1:0] div_reg, div_next;
  logic [A-1:0]     audio_reg, audio_next;

  assign audio_req = (div_reg == DIV_W'(AUD_DIV - 1));
  assign audio     = audio_reg;

  always_comb begin
    div_next   = div_reg + DIV_W'(1);
    audio_next = audio_reg;
    if (audio_req) begin
      div_next   = '0;
      audio_next = tx_en ? audio_in : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg   <= '0;
      audio_reg <= '0;
    end else begin
      div_reg   <= div_next;
      audio_reg <= audio_next;
    end
  end

endmodule

// File: rtl/fm_tx_ctrl.sv
// Byte-serial configuration front end for fm_modulator: decodes opcodes,
// gathers payloads into a shadow word and commits acc_inc/df_inc atomically.
module fm_tx_ctrl
  import fm_pkg::*;
#(
  parameter int          N           = 18,
  parameter int          L           = 12,
  parameter int          A           = 8,
  parameter int unsigned ACC_INC_RST = 32'(ACC_INC_DEF),
  parameter int unsigned DF_INC_RST  = 32'(DF_INC_DEF),
  parameter int          AUD_DIV     = 1134,
  parameter int          TIMEOUT     = 65535
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic [7:0]          cfg_data,
  output logic                cfg_ready,
  input  logic [A-1:0]        audio_in,
  output logic                audio_req,
  output logic signed [A-1:0] audio,
  output logic [N-1:0]        acc_inc,
  output logic [L-1:0]        df_inc,
  output logic                tx_en,
  output logic                err
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t            state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [23:0]       shadow_reg, shadow_next;
  logic              carrier_reg, carrier_next;
  logic [IDLE_W-1:0] idle_reg, idle_next;
  logic [N-1:0]      acc_inc_reg, acc_inc_next;
  logic [L-1:0]      df_inc_reg, df_inc_next;
  logic              tx_en_reg, tx_en_next;
  logic              err_reg, err_next;
  logic              xfer;

  assign cfg_ready = (state_reg != ST_COMMIT);
  assign xfer      = cfg_valid & cfg_ready;

  assign acc_inc = acc_inc_reg;
  assign df_inc  = df_inc_reg;
  assign tx_en   = tx_en_reg;
  assign err     = err_reg;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    shadow_next  = shadow_reg;
    carrier_next = carrier_reg;
    idle_next    = idle_reg;
    acc_inc_next = acc_inc_reg;
    df_inc_next  = df_inc_reg;
    tx_en_next   = tx_en_reg;
    err_next     = 1'b0;

    case (state_reg)
      ST_CMD: begin
        if (xfer) begin
          idle_next   = '0;
          shadow_next = '0;
          case (cfg_data)
            OP_SET_CARRIER: begin
              cnt_next     = 2'(CNT_CARRIER);
              carrier_next = 1'b1;
              state_next   = ST_PAYLOAD;
            end
            OP_SET_DEV: begin
              cnt_next     = 2'(CNT_DEV);
              carrier_next = 1'b0;
              state_next   = ST_PAYLOAD;
            end
            OP_ENABLE:  tx_en_next = 1'b1;
            OP_DISABLE: tx_en_next = 1'b0;
            default:    err_next   = 1'b1;
          endcase
        end
      end

      ST_PAYLOAD: begin
        if (xfer) begin
          shadow_next = {shadow_reg[15:0], cfg_data};
          cnt_next    = cnt_reg - 2'd1;
          idle_next   = '0;
          if (cnt_reg == 2'd1) state_next = ST_COMMIT;
        end else if (idle_reg == IDLE_W'(TIMEOUT - 1)) begin
          // Stalled sender: drop the partial word, live registers stay intact.
          err_next    = 1'b1;
          shadow_next = '0;
          idle_next   = '0;
          state_next  = ST_CMD;
        end else begin
          idle_next = idle_reg + IDLE_W'(1);
        end
      end

      ST_COMMIT: begin
        if (carrier_reg) acc_inc_next = shadow_reg[N-1:0];
        else             df_inc_next  = shadow_reg[L-1:0];
        state_next = ST_CMD;
      end

      default: state_next = ST_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_CMD;
      cnt_reg     <= '0;
      shadow_reg  <= '0;
      carrier_reg <= 1'b0;
      idle_reg    <= '0;
      acc_inc_reg <= N'(ACC_INC_RST);
      df_inc_reg  <= L'(DF_INC_RST);
      tx_en_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shadow_reg  <= shadow_next;
      carrier_reg <= carrier_next;
      idle_reg    <= idle_next;
      acc_inc_reg <= acc_inc_next;
      df_inc_reg  <= df_inc_next;
      tx_en_reg   <= tx_en_next;
      err_reg     <= err_next;
    end
  end

  fm_audio_pacer #(
    .A       (A),
    .AUD_DIV (AUD_DIV)
  ) u_pacer (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_en     (tx_en_reg),
    .audio_in  (audio_in),
    .audio_req (audio_req),
    .audio     (audio)
  );

endmodule
